core_clk_stepper: RTL

//  Generates the gated core clock clk_core that drives the pipeline CPU on the board.

---
 rtl/core_clk_stepper_if.sv | 24 ++
 rtl/core_clk_stepper.sv | 122 ++++++++++++
 2 files changed

// File: rtl/core_clk_stepper_if.sv
// Board-side control and core-clock status bundle for core_clk_stepper.
// The master drives the switch/button/divider controls; the slave (stepper) returns the core clock status.
interface core_clk_stepper_if #(
  parameter int CNT_W = 32
);
  logic             mode_run;
  logic             step_btn;
  logic [3:0]       div_sel;
  logic             halt;
  logic             clk_core;
  logic             core_posedge;
  logic [CNT_W-1:0] cycle_count;
  logic [2:0]       state_dbg;

  modport master (
    output mode_run, step_btn, div_sel, halt,
    input  clk_core, core_posedge, cycle_count, state_dbg
  );

  modport slave (
    input  mode_run, step_btn, div_sel, halt,
    output clk_core, core_posedge, cycle_count, state_dbg
  );
endinterface

// File: rtl/core_clk_stepper.sv
// Gated core clock generator: free-run divided clock or one debounced single step per button press.
// All outputs are registered in the clk domain; clk_core changes on the same edge as the FSM transition.
module core_clk_stepper #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2,
  parameter int CNT_W           = 32
) (
  input  logic               clk,
  input  logic               rstn,
  core_clk_stepper_if.slave  bus
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN_HI  = 3'd1,
    RUN_LO  = 3'd2,
    STEP_HI = 3'd3,
    STEP_LO = 3'd4
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   db_q, db_d;
  logic                   db_prev_q, db_prev_d;
  logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
  state_e                 state_q, state_d;
  logic [15:0]            ph_cnt_q, ph_cnt_d;
  logic [15:0]            ph_lim_q, ph_lim_d;
  logic                   clk_core_q, clk_core_d;
  logic                   core_posedge_q, core_posedge_d;
  logic [CNT_W-1:0]       cycle_count_q, cycle_count_d;

  logic synced;
  logic step_req;
  logic phase_done;
  logic run_ok;

  // Synchroniser and debouncer: the level is accepted only after it differs for DEBOUNCE_CYCLES in a row.
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], bus.step_btn};
    synced    = sync_q[SYNC_STAGES-1];
    db_d      = db_q;
    db_cnt_d  = '0;
    db_prev_d = db_q;
    if (synced != db_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        db_d = synced;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
    step_req = db_q & ~db_prev_q;
  end

  always_comb begin
    state_d    = state_q;
    phase_done = (ph_cnt_q == ph_lim_q);
    run_ok     = bus.mode_run & ~bus.halt;
    case (state_q)
      IDLE: begin
        if (run_ok) begin
          state_d = RUN_HI;
        end else if (step_req && !bus.mode_run) begin
          state_d = STEP_HI;
        end
      end
      RUN_HI:  if (phase_done) state_d = RUN_LO;
      RUN_LO:  if (phase_done) state_d = run_ok ? RUN_HI : IDLE;
      STEP_HI: if (phase_done) state_d = STEP_LO;
      STEP_LO: if (phase_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // div_sel is latched only when a new phase starts, so phases are never truncated or stretched.
    ph_lim_d = ph_lim_q;
    if (state_d != state_q) begin
      ph_cnt_d = '0;
      ph_lim_d = (16'd1 << bus.div_sel) - 16'd1;
    end else if (state_q == IDLE) begin
      ph_cnt_d = '0;
    end else begin
      ph_cnt_d = ph_cnt_q + 16'd1;
    end

    clk_core_d     = (state_d == RUN_HI) || (state_d == STEP_HI);
    core_posedge_d = clk_core_d & ~clk_core_q;
    cycle_count_d  = cycle_count_q + CNT_W'(core_posedge_d);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync_q         <= '0;
      db_q           <= 1'b0;
      db_prev_q      <= 1'b0;
      db_cnt_q       <= '0;
      state_q        <= IDLE;
      ph_cnt_q       <= '0;
      ph_lim_q       <= '0;
      clk_core_q     <= 1'b0;
      core_posedge_q <= 1'b0;
      cycle_count_q  <= '0;
    end else begin
      sync_q         <= sync_d;
      db_q           <= db_d;
      db_prev_q      <= db_prev_d;
      db_cnt_q       <= db_cnt_d;
      state_q        <= state_d;
      ph_cnt_q       <= ph_cnt_d;
      ph_lim_q       <= ph_lim_d;
      clk_core_q     <= clk_core_d;
      core_posedge_q <= core_posedge_d;
      cycle_count_q  <= cycle_count_d;
    end
  end

  assign bus.clk_core     = clk_core_q;
  assign bus.core_posedge = core_posedge_q;
  assign bus.cycle_count  = cycle_count_q;
  assign bus.state_dbg    = state_q;

endmodule
